nv_nvdla_pdp_wdma_pack: RTL and testbench

- Sink end of the PDP datapath output stream (pdp_dp2wdma valid/ready, 8-bit pd, throughput 1).
- Gathers eight consecutive pooled bytes (one 8-channel atom of one output pixel) into a 64-bit DMA write request.
- Generates the write address from the output cube geometry and destination strides.
- Signals done after the last atom of the cube is accepted downstream.

---
 rtl/nv_nvdla_pdp_wdma_pack.sv | 164 ++++++++++++++++
 tb/tb_nv_nvdla_pdp_wdma_pack.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/nv_nvdla_pdp_wdma_pack.sv
// PDP write-DMA packer: gathers eight pooled bytes per atom into one 64-bit
// DMA write request, walking the output cube surface/line/pixel for addresses.
module nv_nvdla_pdp_wdma_pack #(
  parameter int unsigned AW         = 32,
  parameter int unsigned ATOM_BYTES = 8
) (
  input  logic                      nvdla_core_clk,
  input  logic                      nvdla_core_rstn,
  input  logic                      reg2dp_op_en,
  input  logic [12:0]               reg2dp_cube_out_width,
  input  logic [12:0]               reg2dp_cube_out_height,
  input  logic [12:0]               reg2dp_cube_out_channel,
  input  logic [AW-1:0]             reg2dp_dst_base_addr,
  input  logic [AW-1:0]             reg2dp_dst_line_stride,
  input  logic [AW-1:0]             reg2dp_dst_surface_stride,
  input  logic                      pdp_dp2wdma_valid,
  input  logic [7:0]                pdp_dp2wdma_pd,
  output logic                      pdp_dp2wdma_ready,
  output logic                      dma_wr_req_valid,
  input  logic                      dma_wr_req_ready,
  output logic [AW-1:0]             dma_wr_req_addr,
  output logic [8*ATOM_BYTES-1:0]   dma_wr_req_data,
  output logic [ATOM_BYTES-1:0]     dma_wr_req_mask,
  output logic                      wdma_done
);

  localparam int unsigned BW = $clog2(ATOM_BYTES);
  localparam int unsigned CW = 13;
  localparam int unsigned SW = CW - BW;

  typedef enum logic [1:0] {IDLE, BUSY, FLUSH, DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cfg_w, cfg_h, cfg_c;
  logic [AW-1:0] cfg_ls, cfg_ss;

  logic [BW-1:0] b_cnt;
  logic [CW-1:0] w_cnt, h_cnt;
  logic [SW-1:0] s_cnt;

  // surf_addr = base + s*surface_stride, line_addr = surf_addr + h*line_stride
  logic [AW-1:0] surf_addr, line_addr, w_off;

  logic [ATOM_BYTES-2:0][7:0] pack_reg;

  logic start, accept, b_last, w_last, h_last, s_last, atom_done, cube_last, req_fire;

  // Byte enables for the final, possibly partial, surface.
  function automatic logic [ATOM_BYTES-1:0] tail_mask(input logic [BW-1:0] top);
    logic [ATOM_BYTES-1:0] m;
    m = '0;
    for (int k = 0; k < ATOM_BYTES; k++) m[k] = (BW'(k) <= top);
    return m;
  endfunction

  assign start     = (state == IDLE) & reg2dp_op_en;
  assign b_last    = (b_cnt == BW'(ATOM_BYTES - 1));
  assign w_last    = (w_cnt == cfg_w);
  assign h_last    = (h_cnt == cfg_h);
  assign s_last    = (s_cnt == cfg_c[CW-1:BW]);
  assign req_fire  = dma_wr_req_valid & dma_wr_req_ready;

  // Stall only the atom-completing byte while the output register is still full.
  assign pdp_dp2wdma_ready = (state == BUSY) &
                             ~(b_last & dma_wr_req_valid & ~dma_wr_req_ready);

  assign accept    = pdp_dp2wdma_valid & pdp_dp2wdma_ready;
  assign atom_done = accept & b_last;
  assign cube_last = atom_done & w_last & h_last & s_last;

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) state <= IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (reg2dp_op_en) state_nxt = BUSY;
      BUSY:    if (cube_last)    state_nxt = FLUSH;
      FLUSH:   if (req_fire)     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      cfg_w            <= '0;
      cfg_h            <= '0;
      cfg_c            <= '0;
      cfg_ls           <= '0;
      cfg_ss           <= '0;
      b_cnt            <= '0;
      w_cnt            <= '0;
      h_cnt            <= '0;
      s_cnt            <= '0;
      surf_addr        <= '0;
      line_addr        <= '0;
      w_off            <= '0;
      pack_reg         <= '0;
      dma_wr_req_valid <= 1'b0;
      dma_wr_req_addr  <= '0;
      dma_wr_req_data  <= '0;
      dma_wr_req_mask  <= '0;
      wdma_done        <= 1'b0;
    end else begin
      wdma_done <= (state == DONE);

      if (start) begin
        cfg_w     <= reg2dp_cube_out_width;
        cfg_h     <= reg2dp_cube_out_height;
        cfg_c     <= reg2dp_cube_out_channel;
        cfg_ls    <= reg2dp_dst_line_stride;
        cfg_ss    <= reg2dp_dst_surface_stride;
        b_cnt     <= '0;
        w_cnt     <= '0;
        h_cnt     <= '0;
        s_cnt     <= '0;
        w_off     <= '0;
        surf_addr <= reg2dp_dst_base_addr;
        line_addr <= reg2dp_dst_base_addr;
      end

      // Byte/pixel/line/surface counters with address accumulators.
      if (accept) begin
        if (b_last) begin
          b_cnt <= '0;
          if (w_last) begin
            w_cnt <= '0;
            w_off <= '0;
            if (h_last) begin
              h_cnt     <= '0;
              s_cnt     <= s_last ? '0 : s_cnt + SW'(1);
              surf_addr <= surf_addr + cfg_ss;
              line_addr <= surf_addr + cfg_ss;
            end else begin
              h_cnt     <= h_cnt + CW'(1);
              line_addr <= line_addr + cfg_ls;
            end
          end else begin
            w_cnt <= w_cnt + CW'(1);
            w_off <= w_off + AW'(ATOM_BYTES);
          end
        end else begin
          pack_reg[b_cnt] <= pdp_dp2wdma_pd;
          b_cnt           <= b_cnt + BW'(1);
        end
      end

      // Output register: a reload wins over a same-cycle drain (no bubble).
      if (atom_done) begin
        dma_wr_req_valid <= 1'b1;
        dma_wr_req_addr  <= line_addr + w_off;
        dma_wr_req_data  <= {pdp_dp2wdma_pd, pack_reg};
        dma_wr_req_mask  <= s_last ? tail_mask(cfg_c[BW-1:0]) : '1;
      end else if (req_fire) begin
        dma_wr_req_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nv_nvdla_pdp_wdma_pack.sv
// Bench for nv_nvdla_pdp_wdma_pack: directed and random operations checked
// against a cube-walk reference model built from plain arithmetic.
module tb_nv_nvdla_pdp_wdma_pack;

  logic        clk = 1'b0;
  logic        rstn;
  logic        op_en;
  logic [12:0] cw, ch, cc;
  logic [31:0] base, ls, ss;
  logic        in_valid;
  logic [7:0]  in_pd;
  logic        in_ready;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [63:0] req_data;
  logic [7:0]  req_mask;
  logic        done;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  nv_nvdla_pdp_wdma_pack dut (
    .nvdla_core_clk            (clk),
    .nvdla_core_rstn           (rstn),
    .reg2dp_op_en              (op_en),
    .reg2dp_cube_out_width     (cw),
    .reg2dp_cube_out_height    (ch),
    .reg2dp_cube_out_channel   (cc),
    .reg2dp_dst_base_addr      (base),
    .reg2dp_dst_line_stride    (ls),
    .reg2dp_dst_surface_stride (ss),
    .pdp_dp2wdma_valid         (in_valid),
    .pdp_dp2wdma_pd            (in_pd),
    .pdp_dp2wdma_ready         (in_ready),
    .dma_wr_req_valid          (req_valid),
    .dma_wr_req_ready          (req_ready),
    .dma_wr_req_addr           (req_addr),
    .dma_wr_req_data           (req_data),
    .dma_wr_req_mask           (req_mask),
    .wdma_done                 (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " ready"}, 64'(in_ready), 64'(0));
    chk({tag, " req_valid"}, 64'(req_valid), 64'(0));
    chk({tag, " addr"}, 64'(req_addr), 64'(0));
    chk({tag, " data"}, req_data, 64'(0));
    chk({tag, " mask"}, 64'(req_mask), 64'(0));
    chk({tag, " done"}, 64'(done), 64'(0));
  endtask

  // vmode: 0 valid always, 1 random gaps. rmode: 0 ready high, 1 random, 2 low for t in [9,18).
  task automatic run_op(input int w, input int h, input int c,
                        input logic [31:0] b_addr, input logic [31:0] l_str, input logic [31:0] s_str,
                        input int vmode, input int rmode, input bit seq_bytes,
                        input bit poke, input bit scramble, input int abort_at, input string name);
    logic [7:0]  bytes [$];
    logic [31:0] e_addr [$];
    logic [63:0] e_data [$];
    logic [7:0]  e_mask [$];
    logic [63:0] d;
    int s_max, n_atoms, n, k, idx, req_i, done_t, done_cnt, stall_cnt, first_acc, last_acc, limit;
    bit pend, busy, acc, exp_ready, finished, aborted;

    s_max   = c >> 3;
    n_atoms = (w + 1) * (h + 1) * (s_max + 1);
    n       = 8 * n_atoms;
    for (int i = 0; i < n; i++) bytes.push_back(seq_bytes ? 8'(i + 1) : 8'($urandom));
    k = 0;
    for (int s = 0; s <= s_max; s++)
      for (int hh = 0; hh <= h; hh++)
        for (int ww = 0; ww <= w; ww++) begin
          e_addr.push_back(b_addr + 32'(s) * s_str + 32'(hh) * l_str + 32'(ww * 8));
          d = '0;
          for (int bb = 0; bb < 8; bb++) d[8*bb +: 8] = bytes[8*k + bb];
          e_data.push_back(d);
          e_mask.push_back((s == s_max) ? 8'((1 << ((c & 7) + 1)) - 1) : 8'hFF);
          k++;
        end

    @(posedge clk); #1;
    op_en = 1'b1; cw = 13'(w); ch = 13'(h); cc = 13'(c);
    base = b_addr; ls = l_str; ss = s_str;
    in_valid = 1'b0; req_ready = 1'b1;
    @(negedge clk);
    chk({name, " ready_at_start"}, 64'(in_ready), 64'(0));

    idx = 0; req_i = 0; done_t = -1; done_cnt = 0; stall_cnt = 0;
    first_acc = -1; last_acc = -1; pend = 0; finished = 0; aborted = 0;
    limit = n * 16 + 100;
    for (int t = 1; t <= limit; t++) begin
      @(posedge clk); #1;
      if (abort_at >= 0 && idx == abort_at) begin
        rstn = 1'b0; in_valid = 1'b0; op_en = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_idle_outputs({name, " in_reset"});
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          chk({name, " post_reset_done"}, 64'(done), 64'(0));
          chk({name, " post_reset_req_valid"}, 64'(req_valid), 64'(0));
          chk({name, " post_reset_ready"}, 64'(in_ready), 64'(0));
        end
        aborted = 1;
        break;
      end
      op_en = poke && (t == 5);
      if (scramble) begin
        cw = 13'($urandom); ch = 13'($urandom); cc = 13'($urandom);
        base = $urandom; ls = $urandom; ss = $urandom;
      end
      in_valid  = (idx < n) && (vmode == 0 || $urandom_range(3) != 0);
      in_pd     = (idx < n) ? bytes[idx] : 8'($urandom);
      req_ready = (rmode == 0) ? 1'b1 :
                  (rmode == 1) ? 1'($urandom_range(1)) : !(t >= 9 && t < 18);
      @(negedge clk);
      busy      = (idx < n);
      exp_ready = busy && !((idx % 8 == 7) && pend && !req_ready);
      chk({name, " ready"}, 64'(in_ready), 64'(exp_ready));
      chk({name, " req_valid"}, 64'(req_valid), 64'(pend));
      chk({name, " done"}, 64'(done), 64'(t == done_t));
      if (busy && !in_ready) stall_cnt++;
      acc = in_valid && in_ready;
      if (acc) begin
        if (first_acc < 0) first_acc = t;
        last_acc = t;
      end
      if (req_valid && req_ready) begin
        if (req_i < n_atoms) begin
          chk({name, $sformatf(" addr[%0d]", req_i)}, 64'(req_addr), 64'(e_addr[req_i]));
          chk({name, $sformatf(" data[%0d]", req_i)}, req_data, e_data[req_i]);
          chk({name, $sformatf(" mask[%0d]", req_i)}, 64'(req_mask), 64'(e_mask[req_i]));
        end else begin
          chk({name, " req_overflow"}, 64'(req_i), 64'(n_atoms - 1));
        end
        req_i++;
        if (req_i == n_atoms) done_t = t + 2;
      end
      if (done) done_cnt++;
      if (acc && (idx % 8 == 7)) pend = 1;
      else if (pend && req_ready) pend = 0;
      if (acc) idx++;
      if (done_t >= 0 && t >= done_t + 1) begin
        finished = 1;
        break;
      end
    end
    in_valid = 1'b0;
    op_en    = 1'b0;
    if (aborted) return;

    chk({name, " finished_in_budget"}, 64'(finished), 64'(1));
    chk({name, " bytes_accepted"}, 64'(idx), 64'(n));
    chk({name, " req_count"}, 64'(req_i), 64'(n_atoms));
    chk({name, " done_pulses"}, 64'(done_cnt), 64'(1));
    if (vmode == 0 && rmode == 0) begin
      chk({name, " first_accept_cycle"}, 64'(first_acc), 64'(1));
      chk({name, " accept_span"}, 64'(last_acc - first_acc), 64'(n - 1));
    end
    if (vmode == 0 && rmode == 2)
      chk({name, " stall_cycles"}, 64'(stall_cnt), 64'(2));
  endtask

  initial begin
    rstn = 1'b0; op_en = 1'b0; cw = '0; ch = '0; cc = '0;
    base = '0; ls = '0; ss = '0; in_valid = 1'b0; in_pd = '0; req_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    run_op(0, 0, 0, 32'h1000, 32'h0, 32'h0, 0, 0, 1'b1, 1'b0, 1'b0, -1, "basic");
    run_op(1, 1, 15, 32'h0, 32'h40, 32'h100, 0, 0, 1'b0, 1'b1, 1'b1, -1, "geometry");
    run_op(1, 0, 10, 32'h4000, 32'h10, 32'h80, 1, 1, 1'b0, 1'b0, 1'b1, -1, "partial");
    run_op(3, 0, 7, 32'h8000, 32'h100, 32'h1000, 0, 2, 1'b0, 1'b0, 1'b0, -1, "backpressure");
    run_op(7, 0, 7, $urandom & 32'hFFFF_FFF8, 32'h200, 32'h2000, 0, 0, 1'b0, 1'b0, 1'b0, -1, "throughput");
    run_op(3, 1, 15, 32'h3000, 32'h40, 32'h400, 0, 0, 1'b0, 1'b0, 1'b0, 20, "abort");
    run_op(1, 1, 7, 32'h3000, 32'h40, 32'h400, 0, 0, 1'b0, 1'b0, 1'b0, -1, "restart");
    for (int r = 0; r < 3; r++)
      run_op(int'($urandom_range(3)), int'($urandom_range(2)), int'($urandom_range(40)),
             $urandom, $urandom, $urandom, 1, 1, 1'b0, 1'b1, 1'b1, -1, $sformatf("random%0d", r));

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_mis);
    $fatal(1, "watchdog expired");
  end

endmodule
